microcode_sequencer: RTL



---
 rtl/microcode_sequencer_pkg.sv | 23 ++
 rtl/useq_counter.sv | 37 +++
 rtl/microcode_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/microcode_sequencer_pkg.sv
// Shared types and constants for the microcode sequencer.
package microcode_sequencer_pkg;

  localparam int unsigned UADDR_W     = 19;
  localparam int unsigned UPC_W       = 4;
  localparam int unsigned INIT_CYCLES = 4;

  // Bit-field offsets of the composed microcode address.
  localparam int unsigned IRQ_BIT   = 18;
  localparam int unsigned FLAGS_MSB = 17;
  localparam int unsigned FLAGS_LSB = 14;
  localparam int unsigned OP_MSB    = 13;
  localparam int unsigned OP_LSB    = 4;
  localparam int unsigned UPC_MSB   = 3;
  localparam int unsigned UPC_LSB   = 0;

  typedef enum logic [1:0] {
    StInit = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } useq_state_e;

endpackage

// File: rtl/useq_counter.sv
// Micro-step counter: synchronous clear, enable, and a wrap strobe on 15 -> 0.
module useq_counter
  import microcode_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [UPC_W-1:0] count,
  output logic             wrap
);

  logic [UPC_W-1:0] count_q, count_d;

  // Next count: clear wins over enable.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + UPC_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = en && !clear && (count_q == {UPC_W{1'b1}});

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: builds the control-store address and steps through
// micro-instructions, handling bus waits, interrupts, halt and overflow.
module microcode_sequencer
  import microcode_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        ir,
  input  logic [3:0]         flags,
  input  logic               irq,
  input  logic               end_instr,
  input  logic               wait_n,
  input  logic               halt,
  output logic [UADDR_W-1:0] uaddr,
  output logic               cs_noe,
  output logic [UPC_W-1:0]   upc,
  output logic               in_irq,
  output logic               halted,
  output logic               uovf
);

  useq_state_e state_q, state_d;
  logic [1:0]  init_cnt_q, init_cnt_d;
  logic        in_irq_q, in_irq_d;
  logic        uovf_q;
  logic        cnt_clear, cnt_en, cnt_wrap;
  logic        boundary;
  logic        unused_ir;

  assign unused_ir = ^ir[5:0];
  assign boundary  = (state_q == StRun) && wait_n && end_instr;

  useq_counter u_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (upc),
    .wrap  (cnt_wrap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a halt request is only honoured at an instruction boundary.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit: if (init_cnt_q == 2'(INIT_CYCLES - 1)) state_d = StRun;
      StRun:  if (boundary && halt) state_d = StHalt;
      StHalt: if (!halt) state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // Outputs and counter controls decoded from the current state.
  always_comb begin
    cs_noe    = 1'b0;
    halted    = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      StInit: begin
        cs_noe    = 1'b1;
        cnt_clear = 1'b1;
      end
      StRun: begin
        cnt_clear = boundary;
        cnt_en    = wait_n && !end_instr;
      end
      StHalt: begin
        halted    = 1'b1;
        cnt_clear = 1'b1;
      end
      default: begin
        cs_noe    = 1'b1;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // Datapath next values: INIT counter and interrupt latch.
  always_comb begin
    init_cnt_d = (state_q == StInit) ? init_cnt_q + 2'd1 : 2'd0;
    in_irq_d   = in_irq_q;
    // Halt beats a coincident irq, so the interrupt is dropped rather than latched.
    if (boundary) begin
      in_irq_d = halt ? 1'b0 : irq;
    end
  end

  // Datapath registers; overflow is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt_q <= 2'd0;
      in_irq_q   <= 1'b0;
      uovf_q     <= 1'b0;
    end else begin
      init_cnt_q <= init_cnt_d;
      in_irq_q   <= in_irq_d;
      if (cnt_wrap) begin
        uovf_q <= 1'b1;
      end
    end
  end

  assign in_irq = in_irq_q;
  assign uovf   = uovf_q;

  // Address is purely combinational so ir/flags changes reach the store immediately.
  always_comb begin
    uaddr                      = '0;
    uaddr[IRQ_BIT]             = in_irq_q;
    uaddr[FLAGS_MSB:FLAGS_LSB] = flags;
    uaddr[OP_MSB:OP_LSB]       = ir[15:6];
    uaddr[UPC_MSB:UPC_LSB]     = upc;
  end

endmodule
